// File: rtl/hit_judge_if.sv
// Bundles the player inputs and renderer-facing outputs of the hit judge.
// The master side drives positions, attack flags and restart; the slave side drives health and round status.
interface hit_judge_if #(
  parameter int HP_W = 4
);
  logic [9:0]      p1_x_in;
  logic [9:0]      p2_x_in;
  logic            p1_attack_active;
  logic            p2_attack_active;
  logic            restart_in;
  logic [HP_W-1:0] p1_health_out;
  logic [HP_W-1:0] p2_health_out;
  logic            p1_hit_pulse;
  logic            p2_hit_pulse;
  logic            freeze_out;
  logic            round_over;
  logic [1:0]      winner_out;

  modport master (
    output p1_x_in, p2_x_in, p1_attack_active, p2_attack_active, restart_in,
    input  p1_health_out, p2_health_out, p1_hit_pulse, p2_hit_pulse,
           freeze_out, round_over, winner_out
  );

  modport slave (
    input  p1_x_in, p2_x_in, p1_attack_active, p2_attack_active, restart_in,
    output p1_health_out, p2_health_out, p1_hit_pulse, p2_hit_pulse,
           freeze_out, round_over, winner_out
  );
endinterface

// File: rtl/hit_judge.sv
// Hit detection, damage and round FSM (FIGHT/HITSTOP/KO) for a two-player fighter.
// P1 faces right and P2 faces left, so both hitboxes cover the gap between the players.
module hit_judge #(
  parameter int CHAR_W        = 32,
  parameter int REACH         = 24,
  parameter int HP_MAX        = 5,
  parameter int HP_W          = 4,
  parameter int DAMAGE        = 1,
  parameter int HITSTOP_TICKS = 4
) (
  input  logic     clk_game,
  input  logic     reset_n,
  hit_judge_if.slave bus
);
  localparam int CNT_W = (HITSTOP_TICKS > 1) ? $clog2(HITSTOP_TICKS) : 1;

  typedef enum logic [1:0] {
    ST_FIGHT   = 2'd0,
    ST_HITSTOP = 2'd1,
    ST_KO      = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HP_W-1:0] p1_hp_q, p1_hp_d, p2_hp_q, p2_hp_d;
  logic            p1_pulse_q, p1_pulse_d, p2_pulse_q, p2_pulse_d;
  logic            freeze_q, freeze_d, round_over_q, round_over_d;
  logic [1:0]      winner_q, winner_d;
  logic            p1_landed_q, p1_landed_d, p2_landed_q, p2_landed_d;
  logic            restart_q, restart_d;

  logic [10:0] p1_left_s, p2_left_s, p1_right_s, p2_right_s, reach_end_s;
  logic        p1_connects_s, p2_connects_s, p1_strike_s, p2_strike_s, restart_rise_s;

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp);
    if (hp < HP_W'(DAMAGE)) begin
      return {HP_W{1'b0}};
    end else begin
      return hp - HP_W'(DAMAGE);
    end
  endfunction

  // Hitbox geometry in 11 bits so right edges never wrap.
  always_comb begin
    p1_left_s      = {1'b0, bus.p1_x_in};
    p2_left_s      = {1'b0, bus.p2_x_in};
    p1_right_s     = p1_left_s + 11'(CHAR_W);
    p2_right_s     = p2_left_s + 11'(CHAR_W);
    reach_end_s    = p1_right_s + 11'(REACH);
    p1_connects_s  = bus.p1_attack_active & (p1_right_s < p2_right_s) & (p2_left_s < reach_end_s);
    p2_connects_s  = bus.p2_attack_active & (p1_left_s < p2_left_s) & (p2_left_s < reach_end_s);
    p1_strike_s    = p1_connects_s & ~p1_landed_q & (state_q == ST_FIGHT);
    p2_strike_s    = p2_connects_s & ~p2_landed_q & (state_q == ST_FIGHT);
    restart_rise_s = bus.restart_in & ~restart_q;
  end

  // Next-state, damage and output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    p1_hp_d      = p1_hp_q;
    p2_hp_d      = p2_hp_q;
    p1_pulse_d   = p2_strike_s;
    p2_pulse_d   = p1_strike_s;
    freeze_d     = freeze_q;
    round_over_d = round_over_q;
    winner_d     = winner_q;
    restart_d    = bus.restart_in;
    // A latch drops the moment its attack ends, in every state.
    p1_landed_d  = bus.p1_attack_active & (p1_landed_q | p1_strike_s);
    p2_landed_d  = bus.p2_attack_active & (p2_landed_q | p2_strike_s);

    if (p2_strike_s) begin
      p1_hp_d = sat_sub(p1_hp_q);
    end else begin
      p1_hp_d = p1_hp_q;
    end
    if (p1_strike_s) begin
      p2_hp_d = sat_sub(p2_hp_q);
    end else begin
      p2_hp_d = p2_hp_q;
    end

    case (state_q)
      ST_FIGHT: begin
        round_over_d = 1'b0;
        if (p1_strike_s | p2_strike_s) begin
          state_d  = ST_HITSTOP;
          cnt_d    = CNT_W'(HITSTOP_TICKS - 1);
          freeze_d = 1'b1;
        end else begin
          freeze_d = 1'b0;
        end
      end
      ST_HITSTOP: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          freeze_d = 1'b0;
          if ((p1_hp_q == {HP_W{1'b0}}) || (p2_hp_q == {HP_W{1'b0}})) begin
            state_d      = ST_KO;
            round_over_d = 1'b1;
            winner_d     = {p1_hp_q == {HP_W{1'b0}}, p2_hp_q == {HP_W{1'b0}}};
          end else begin
            state_d = ST_FIGHT;
          end
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          freeze_d = 1'b1;
        end
      end
      ST_KO: begin
        freeze_d = 1'b0;
        if (restart_rise_s) begin
          state_d      = ST_FIGHT;
          p1_hp_d      = HP_W'(HP_MAX);
          p2_hp_d      = HP_W'(HP_MAX);
          winner_d     = 2'b00;
          round_over_d = 1'b0;
          p1_landed_d  = 1'b0;
          p2_landed_d  = 1'b0;
        end else begin
          round_over_d = 1'b1;
        end
      end
      default: begin
        state_d      = ST_FIGHT;
        cnt_d        = {CNT_W{1'b0}};
        freeze_d     = 1'b0;
        round_over_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_game or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_FIGHT;
      cnt_q        <= {CNT_W{1'b0}};
      p1_hp_q      <= HP_W'(HP_MAX);
      p2_hp_q      <= HP_W'(HP_MAX);
      p1_pulse_q   <= 1'b0;
      p2_pulse_q   <= 1'b0;
      freeze_q     <= 1'b0;
      round_over_q <= 1'b0;
      winner_q     <= 2'b00;
      p1_landed_q  <= 1'b0;
      p2_landed_q  <= 1'b0;
      restart_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      p1_hp_q      <= p1_hp_d;
      p2_hp_q      <= p2_hp_d;
      p1_pulse_q   <= p1_pulse_d;
      p2_pulse_q   <= p2_pulse_d;
      freeze_q     <= freeze_d;
      round_over_q <= round_over_d;
      winner_q     <= winner_d;
      p1_landed_q  <= p1_landed_d;
      p2_landed_q  <= p2_landed_d;
      restart_q    <= restart_d;
    end
  end

  assign bus.p1_health_out = p1_hp_q;
  assign bus.p2_health_out = p2_hp_q;
  assign bus.p1_hit_pulse  = p1_pulse_q;
  assign bus.p2_hit_pulse  = p2_pulse_q;
  assign bus.freeze_out    = freeze_q;
  assign bus.round_over    = round_over_q;
  assign bus.winner_out    = winner_q;
endmodule

// File: tb/tb_hit_judge.sv
// Table-driven bench for hit_judge: each row applies inputs for one clk_game edge and
// compares all outputs afterwards; an async reset during hitstop is checked by hand.
module tb_hit_judge;
  logic clk_game = 1'b0;
  logic reset_n  = 1'b0;
  int   total    = 0;
  int   bad      = 0;

  hit_judge_if #(.HP_W(4)) bus ();

  hit_judge dut (
    .clk_game (clk_game),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  always #5 clk_game = ~clk_game;

  typedef struct {
    logic [9:0] p1x;
    logic [9:0] p2x;
    logic       p1a;
    logic       p2a;
    logic       rs;
    logic [3:0] h1;
    logic [3:0] h2;
    logic       pl1;
    logic       pl2;
    logic       fz;
    logic       ro;
    logic [1:0] w;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] outs();
    return {2'b00, bus.p1_health_out, bus.p2_health_out, bus.p1_hit_pulse,
            bus.p2_hit_pulse, bus.freeze_out, bus.round_over, bus.winner_out};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got hp1/hp2/pl1/pl2/fz/ro/w=%h expected %h", name, act, exp);
    end
  endtask

  task automatic row(input logic [9:0] p1x, input logic [9:0] p2x, input logic p1a,
                     input logic p2a, input logic rs, input logic [3:0] h1, input logic [3:0] h2,
                     input logic pl1, input logic pl2, input logic fz, input logic ro,
                     input logic [1:0] w);
    vec_t v;
    v.p1x = p1x; v.p2x = p2x; v.p1a = p1a; v.p2a = p2a; v.rs = rs;
    v.h1 = h1; v.h2 = h2; v.pl1 = pl1; v.pl2 = pl2; v.fz = fz; v.ro = ro; v.w = w;
    vecs.push_back(v);
  endtask

  // One-cycle attack that lands, four frozen cycles, then the exit edge (FIGHT or KO).
  task automatic add_hit(input logic [9:0] p1x, input logic [9:0] p2x, input logic p1a,
                         input logic p2a, input logic [3:0] h1, input logic [3:0] h2,
                         input logic ko, input logic [1:0] w);
    row(p1x, p2x, p1a, p2a, 1'b0, h1, h2, p2a, p1a, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) row(p1x, p2x, 1'b0, 1'b0, 1'b0, h1, h2, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    row(p1x, p2x, 1'b0, 1'b0, 1'b0, h1, h2, 1'b0, 1'b0, 1'b0, ko, ko ? w : 2'b00);
  endtask

  task automatic tick();
    @(posedge clk_game);
    #1;
  endtask

  task automatic drive(input logic [9:0] p1x, input logic [9:0] p2x, input logic p1a,
                       input logic p2a, input logic rs);
    bus.p1_x_in = p1x; bus.p2_x_in = p2x;
    bus.p1_attack_active = p1a; bus.p2_attack_active = p2a; bus.restart_in = rs;
  endtask

  initial begin
    // P1 held active through the whole hitstop: one hit only.
    for (int i = 0; i < 6; i++)
      row(10'd100, 10'd150, 1'b1, 1'b0, 1'b0, 4'd5, 4'd4, 1'b0, (i == 0), (i < 4), 1'b0, 2'b00);
    row(10'd100, 10'd150, 1'b0, 1'b0, 1'b0, 4'd5, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    // Hitbox edges: 160 and 156 miss, 155 hits.
    row(10'd100, 10'd160, 1'b1, 1'b0, 1'b0, 4'd5, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    row(10'd100, 10'd156, 1'b1, 1'b0, 1'b0, 4'd5, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    add_hit(10'd100, 10'd155, 1'b1, 1'b0, 4'd5, 4'd3, 1'b0, 2'b00);
    // Players crossed over: neither attack connects.
    row(10'd200, 10'd150, 1'b0, 1'b1, 1'b0, 4'd5, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    row(10'd200, 10'd150, 1'b1, 1'b0, 1'b0, 4'd5, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    row(10'd100, 10'd150, 1'b0, 1'b0, 1'b0, 4'd5, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    add_hit(10'd100, 10'd150, 1'b0, 1'b1, 4'd4, 4'd3, 1'b0, 2'b00);
    add_hit(10'd100, 10'd150, 1'b1, 1'b0, 4'd4, 4'd2, 1'b0, 2'b00);
    add_hit(10'd100, 10'd150, 1'b1, 1'b0, 4'd4, 4'd1, 1'b0, 2'b00);
    add_hit(10'd100, 10'd150, 1'b1, 1'b0, 4'd4, 4'd0, 1'b1, 2'b01);
    // KO ignores attacks.
    row(10'd100, 10'd150, 1'b1, 1'b0, 1'b0, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    row(10'd100, 10'd150, 1'b0, 1'b1, 1'b0, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    row(10'd100, 10'd150, 1'b0, 1'b0, 1'b0, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    // Restart from KO, then restart edges in FIGHT do nothing.
    row(10'd100, 10'd150, 1'b0, 1'b0, 1'b1, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    row(10'd100, 10'd150, 1'b0, 1'b0, 1'b0, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    row(10'd100, 10'd150, 1'b0, 1'b0, 1'b1, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    row(10'd100, 10'd150, 1'b0, 1'b0, 1'b0, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    // Trades down to a double KO.
    add_hit(10'd100, 10'd140, 1'b1, 1'b1, 4'd4, 4'd4, 1'b0, 2'b00);
    add_hit(10'd100, 10'd140, 1'b1, 1'b1, 4'd3, 4'd3, 1'b0, 2'b00);
    add_hit(10'd100, 10'd140, 1'b1, 1'b1, 4'd2, 4'd2, 1'b0, 2'b00);
    add_hit(10'd100, 10'd140, 1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 2'b00);
    add_hit(10'd100, 10'd140, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 2'b11);
    row(10'd100, 10'd140, 1'b0, 1'b0, 1'b1, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    row(10'd100, 10'd140, 1'b0, 1'b0, 1'b0, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    // P2 wins.
    add_hit(10'd100, 10'd150, 1'b0, 1'b1, 4'd4, 4'd5, 1'b0, 2'b00);
    add_hit(10'd100, 10'd150, 1'b0, 1'b1, 4'd3, 4'd5, 1'b0, 2'b00);
    add_hit(10'd100, 10'd150, 1'b0, 1'b1, 4'd2, 4'd5, 1'b0, 2'b00);
    add_hit(10'd100, 10'd150, 1'b0, 1'b1, 4'd1, 4'd5, 1'b0, 2'b00);
    add_hit(10'd100, 10'd150, 1'b0, 1'b1, 4'd0, 4'd5, 1'b1, 2'b10);
    row(10'd100, 10'd150, 1'b0, 1'b0, 1'b1, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    row(10'd100, 10'd150, 1'b0, 1'b0, 1'b0, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

    drive(10'd100, 10'd150, 1'b0, 1'b0, 1'b0);
    #12;
    check("reset_state", outs(), {2'b00, 4'd5, 4'd5, 6'b000000});
    @(negedge clk_game);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].p1x, vecs[i].p2x, vecs[i].p1a, vecs[i].p2a, vecs[i].rs);
      tick();
      check($sformatf("row%0d", i), outs(),
            {2'b00, vecs[i].h1, vecs[i].h2, vecs[i].pl1, vecs[i].pl2,
             vecs[i].fz, vecs[i].ro, vecs[i].w});
    end

    // Async reset in the middle of hitstop.
    drive(10'd100, 10'd150, 1'b1, 1'b0, 1'b0);
    tick();
    check("hs_entry", outs(), {2'b00, 4'd5, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00});
    drive(10'd100, 10'd150, 1'b0, 1'b0, 1'b0);
    tick();
    check("hs_frozen", outs(), {2'b00, 4'd5, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00});
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", outs(), {2'b00, 4'd5, 4'd5, 6'b000000});
    @(posedge clk_game);
    @(negedge clk_game);
    reset_n = 1'b1;
    // Back in FIGHT right away: a fresh attack lands on the first edge.
    drive(10'd100, 10'd150, 1'b1, 1'b0, 1'b0);
    tick();
    check("post_reset_hit", outs(), {2'b00, 4'd5, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
